// File: rtl/dense_mac_reuse_pkg.sv
// ----------------------------------------------------------------------------
// dense_mac_reuse_pkg
// Shared definitions for the resource-reuse dense-layer MAC scheduler:
//   - state_e    : scheduler FSM states
//   - clog2/max2 : constant helpers used to size ports and derived widths
//   - sat_hi/lo  : saturation limits of a signed result of a given width
// ----------------------------------------------------------------------------
package dense_mac_reuse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Largest and smallest value of an out_w-bit two's-complement result.
    function automatic longint sat_hi(input int out_w);
        return (longint'(1) << (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int out_w);
        return -(longint'(1) << (out_w - 1));
    endfunction

endpackage

// File: rtl/dense_mac_reuse_mul.sv
// ----------------------------------------------------------------------------
// dense_mac_reuse_mul
// Combinational signed-data x unsigned-weight multiplier shared by every
// product of the dot product. The weight is zero-extended so it is never
// interpreted as negative.
//   a_i : signed data operand   (DIN_W)
//   b_i : unsigned weight       (WGT_W)
//   p_o : exact signed product  (PROD_W = DIN_W + WGT_W)
// ----------------------------------------------------------------------------
module dense_mac_reuse_mul
    import dense_mac_reuse_pkg::*;
#(
    parameter int DIN_W  = 13,
    parameter int WGT_W  = 10,
    parameter int PROD_W = DIN_W + WGT_W
) (
    input  logic signed [DIN_W-1:0]  a_i,
    input  logic        [WGT_W-1:0]  b_i,
    output logic signed [PROD_W-1:0] p_o
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    assign a_ext = PROD_W'(a_i);            // sign-extends: a_i is signed
    assign b_ext = PROD_W'({1'b0, b_i});    // zero-extends the weight

    // A DIN_W-bit signed value times a WGT_W-bit unsigned value always fits in
    // DIN_W+WGT_W signed bits, so keeping only the low PROD_W bits is exact.
    assign p_o = a_ext * b_ext;

endmodule

// File: rtl/dense_mac_reuse_sched.sv
// ----------------------------------------------------------------------------
// dense_mac_reuse_sched
// Time-multiplexed dot-product scheduler: one multiplier is reused for all
// N_IN products. Each accepted input element issues a weight-ROM read; the
// element and the returned weight meet in stage 2 (multiply) and the product
// is accumulated in stage 3. The accumulator starts from the bias, and the
// final sum is saturated to OUT_W bits.
//   ap_clk, ap_rst_n       : clock, asynchronous active-low reset
//   ap_start/ready/idle/done : block-level handshake
//   bias                   : signed bias, sampled with ap_start in IDLE
//   x_tdata/tvalid/tready  : input element stream
//   w_addr, w_ce, w_q      : weight ROM port (w_q valid the cycle after w_ce)
//   res, sat               : saturated result and clip flag, held until the
//                            next ap_done
// ----------------------------------------------------------------------------
module dense_mac_reuse_sched
    import dense_mac_reuse_pkg::*;
#(
    parameter int N_IN   = 16,
    parameter int DIN_W  = 13,
    parameter int WGT_W  = 10,
    parameter int BIAS_W = 16,
    parameter int OUT_W  = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   ap_start,
    output logic                   ap_ready,
    output logic                   ap_idle,
    output logic                   ap_done,
    input  logic [BIAS_W-1:0]      bias,
    input  logic [DIN_W-1:0]       x_tdata,
    input  logic                   x_tvalid,
    output logic                   x_tready,
    output logic [clog2(N_IN)-1:0] w_addr,
    output logic                   w_ce,
    input  logic [WGT_W-1:0]       w_q,
    output logic [OUT_W-1:0]       res,
    output logic                   sat
);

    localparam int PROD_W = DIN_W + WGT_W;
    localparam int ACC_W  = max2(PROD_W, BIAS_W) + clog2(N_IN) + 1;
    localparam int AW     = clog2(N_IN);
    // One extra bit so the increment on the last accept never wraps mid-run.
    localparam int IDX_W  = AW + 1;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(sat_hi(OUT_W));
    localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(sat_lo(OUT_W));

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [DIN_W-1:0]   x_q, x_d;
    logic                      v1_q, v1_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      v2_q, v2_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]          res_q, res_d;
    logic                      sat_q, sat_d;

    logic signed [PROD_W-1:0]  mul_p;
    logic signed [ACC_W-1:0]   clip;
    logic                      clipped;
    logic                      accept;

    dense_mac_reuse_mul #(
        .DIN_W  (DIN_W),
        .WGT_W  (WGT_W),
        .PROD_W (PROD_W)
    ) u_mul (
        .a_i (x_q),
        .b_i (w_q),
        .p_o (mul_p)
    );

    assign accept = (state_q == ST_RUN) && x_tvalid;
    assign w_addr = idx_q[AW-1:0];
    assign res    = res_q;
    assign sat    = sat_q;

    // Accumulator next state: bias load on start, otherwise stage 3.
    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_IDLE) begin
            if (ap_start) begin
                acc_d = ACC_W'($signed(bias));
            end
        end else if (v2_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
    end

    // Saturation of the accumulator value being written this cycle.
    always_comb begin
        clip    = acc_d;
        clipped = 1'b0;
        if (acc_d > SAT_HI) begin
            clip    = SAT_HI;
            clipped = 1'b1;
        end else if (acc_d < SAT_LO) begin
            clip    = SAT_LO;
            clipped = 1'b1;
        end
    end

    // FSM next state, stage 1/2 pipeline and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        x_d      = x_q;
        v1_d     = 1'b0;
        v2_d     = v1_q;
        prod_d   = v1_q ? mul_p : prod_q;
        res_d    = res_q;
        sat_d    = sat_q;
        ap_ready = 1'b0;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        x_tready = 1'b0;
        w_ce     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                x_tready = 1'b1;
                if (accept) begin
                    w_ce  = 1'b1;
                    v1_d  = 1'b1;
                    x_d   = $signed(x_tdata);
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        ap_ready = 1'b1;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Once neither stage holds a product after this edge, acc_d
                // is the final sum: capture the saturated result now so res
                // is already valid in the ap_done cycle.
                if (!v1_d && !v2_d) begin
                    res_d   = clip[OUT_W-1:0];
                    sat_d   = clipped;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ap_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: datapath registers are reset along with the control state, so a
    // reset mid-run discards the partial sum and leaves no stale operand.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            v1_q    <= 1'b0;
            prod_q  <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            v1_q    <= v1_d;
            prod_q  <= prod_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_dense_mac_reuse_sched.sv
// ----------------------------------------------------------------------------
// tb_dense_mac_reuse_sched
// Directed bench for dense_mac_reuse_sched with N_IN = 4. A table of dot
// products with hand-computed results and cycle timing is applied in a loop;
// back-to-back operation and a mid-run reset are exercised as hand-written
// sequences. Cycle 0 is the cycle in which ap_start is presented in IDLE.
// ----------------------------------------------------------------------------
module tb_dense_mac_reuse_sched;

    localparam int N_IN   = 4;
    localparam int DIN_W  = 13;
    localparam int WGT_W  = 10;
    localparam int BIAS_W = 16;
    localparam int OUT_W  = 16;
    localparam int AW     = 2;
    localparam int N_VEC  = 6;
    localparam int MAX_CYC = 60;

    logic               ap_clk;
    logic               ap_rst_n;
    logic               ap_start;
    logic               ap_ready;
    logic               ap_idle;
    logic               ap_done;
    logic [BIAS_W-1:0]  bias;
    logic [DIN_W-1:0]   x_tdata;
    logic               x_tvalid;
    logic               x_tready;
    logic [AW-1:0]      w_addr;
    logic               w_ce;
    logic [WGT_W-1:0]   w_q;
    logic [OUT_W-1:0]   res;
    logic               sat;

    dense_mac_reuse_sched #(
        .N_IN   (N_IN),
        .DIN_W  (DIN_W),
        .WGT_W  (WGT_W),
        .BIAS_W (BIAS_W),
        .OUT_W  (OUT_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .bias     (bias),
        .x_tdata  (x_tdata),
        .x_tvalid (x_tvalid),
        .x_tready (x_tready),
        .w_addr   (w_addr),
        .w_ce     (w_ce),
        .w_q      (w_q),
        .res      (res),
        .sat      (sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Weight ROM with one cycle of read latency.
    logic [N_IN-1:0][WGT_W-1:0] wrom;
    always @(posedge ap_clk) begin
        if (w_ce) w_q <= wrom[w_addr];
    end

    typedef struct {
        logic [BIAS_W-1:0]          bias;
        logic [N_IN-1:0][DIN_W-1:0] x;
        logic [N_IN-1:0][WGT_W-1:0] w;
        logic [15:0]                bubbles;   // bit c: x_tvalid low in cycle c
        int                         exp_res;
        int                         exp_sat;
        int                         exp_done;
        int                         exp_ready;
    } vec_t;

    vec_t vecs[N_VEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int k, input int b,
                           input int x0, input int x1, input int x2, input int x3,
                           input int w0, input int w1, input int w2, input int w3,
                           input logic [15:0] bub, input int er, input int es,
                           input int ed, input int ery);
        vecs[k].bias      = BIAS_W'(b);
        vecs[k].x[0]      = DIN_W'(x0);
        vecs[k].x[1]      = DIN_W'(x1);
        vecs[k].x[2]      = DIN_W'(x2);
        vecs[k].x[3]      = DIN_W'(x3);
        vecs[k].w[0]      = WGT_W'(w0);
        vecs[k].w[1]      = WGT_W'(w1);
        vecs[k].w[2]      = WGT_W'(w2);
        vecs[k].w[3]      = WGT_W'(w3);
        vecs[k].bubbles   = bub;
        vecs[k].exp_res   = er;
        vecs[k].exp_sat   = es;
        vecs[k].exp_done  = ed;
        vecs[k].exp_ready = ery;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ap_ready"}, 64'(ap_ready), 0);
        check({tag, "_ap_idle"},  64'(ap_idle),  1);
        check({tag, "_ap_done"},  64'(ap_done),  0);
        check({tag, "_x_tready"}, 64'(x_tready), 0);
        check({tag, "_w_ce"},     64'(w_ce),     0);
        check({tag, "_w_addr"},   64'(w_addr),   0);
        check({tag, "_res"},      64'(res),      0);
        check({tag, "_sat"},      64'(sat),      0);
    endtask

    // Runs one table entry from IDLE; entered and left at posedge+1.
    task automatic run_vec(input int k, input string tag);
        int cyc, eidx, done_cyc, ready_cyc, wce_cnt, done_cnt, ready_cnt;
        logic signed [OUT_W-1:0] r;
        logic s;
        bit seen;
        cyc = 0; eidx = 0; done_cyc = -1; ready_cyc = -1;
        wce_cnt = 0; done_cnt = 0; ready_cnt = 0; seen = 0;
        r = '0; s = 1'b0;
        wrom = vecs[k].w;
        check({tag, "_idle_before"}, 64'(ap_idle), 1);
        while (!seen && cyc < MAX_CYC) begin
            ap_start = (cyc == 0);
            // Bias is only meaningful with ap_start; drive junk otherwise.
            bias     = (cyc == 0) ? vecs[k].bias : 16'h7ABC;
            x_tvalid = (cyc < 16) ? !vecs[k].bubbles[cyc] : 1'b1;
            x_tdata  = (eidx < N_IN) ? vecs[k].x[eidx] : 13'h1555;
            @(negedge ap_clk);
            if (cyc == 0) check({tag, "_no_accept_idle"}, 64'(x_tready), 0);
            if (w_ce) wce_cnt++;
            if (ap_ready) begin ready_cyc = cyc; ready_cnt++; end
            if (x_tvalid && x_tready) eidx++;
            if (ap_done) begin
                seen = 1; done_cyc = cyc; done_cnt++;
                r = $signed(res); s = sat;
            end
            @(posedge ap_clk); #1;
            cyc++;
        end
        ap_start = 1'b0;
        x_tvalid = 1'b0;
        check({tag, "_done_seen"},  64'(seen),      1);
        check({tag, "_res"},        64'(r),         64'(vecs[k].exp_res));
        check({tag, "_sat"},        64'(s),         64'(vecs[k].exp_sat));
        check({tag, "_done_cycle"}, 64'(done_cyc),  64'(vecs[k].exp_done));
        check({tag, "_ready_cycle"},64'(ready_cyc), 64'(vecs[k].exp_ready));
        check({tag, "_ready_cnt"},  64'(ready_cnt), 1);
        check({tag, "_wce_cnt"},    64'(wce_cnt),   64'(N_IN));
        check({tag, "_res_held"},   64'($signed(res)), 64'(vecs[k].exp_res));
    endtask

    initial begin
        int cyc, run, eidx, d1, d2, idle_between, done_cnt, idle_cnt, tready_cnt;
        logic signed [OUT_W-1:0] r1, r2;
        logic s2;

        //       k  bias    x0     x1     x2     x3     w0    w1    w2  w3   bubbles  res     sat done ready
        set_vec(0,      0,     1,     2,     3,     4,   10,   20,   30, 40, 16'h0000,    300, 0,  7,  4);
        set_vec(1,     -5, -4096, -4096, -4096, -4096, 1023, 1023, 1023, 1023, 16'h0000, -32768, 1, 7, 4);
        set_vec(2,  32760,     1,     0,     0,     2,    3,    9,    9,  4, 16'h0000,  32767, 1,  7,  4);
        set_vec(3,  32755,     1,     0,     0,     2,    3,    9,    9,  4, 16'h0000,  32766, 0,  7,  4);
        // Bubbles in cycles 2, 4, 5: accepts land in cycles 1, 3, 6, 7.
        set_vec(4,      0,     1,     2,     3,     4,   10,   20,   30, 40, 16'h0034,    300, 0, 10,  7);
        // -6 + 5115 + 0 + 77 + 100 = 5286
        set_vec(5,    100,    -3,     5,    -7,    11,    2, 1023,    0,  7, 16'h0000,   5286, 0,  7,  4);

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        bias     = '0;
        x_tdata  = '0;
        x_tvalid = 1'b0;
        wrom     = '0;

        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset_outputs("reset");
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        for (int k = 0; k < N_VEC; k++) begin
            run_vec(k, $sformatf("vec%0d", k));
        end

        // Back-to-back: ap_start held high across vec0 then vec1.
        run = 0; eidx = 0; cyc = 0; d1 = -1; d2 = -1; idle_between = 0;
        r1 = '0; r2 = '0; s2 = 1'b0;
        while (run < 2 && cyc < MAX_CYC) begin
            ap_start = 1'b1;
            bias     = vecs[run].bias;
            wrom     = vecs[run].w;
            x_tvalid = 1'b1;
            x_tdata  = (eidx < N_IN) ? vecs[run].x[eidx] : 13'h0AAA;
            @(negedge ap_clk);
            if (x_tvalid && x_tready) eidx++;
            if (run == 1 && ap_idle) idle_between++;
            if (ap_done) begin
                if (run == 0) begin d1 = cyc; r1 = $signed(res); end
                else begin d2 = cyc; r2 = $signed(res); s2 = sat; end
                run++;
                eidx = 0;
            end
            @(posedge ap_clk); #1;
            cyc++;
        end
        ap_start = 1'b0;
        x_tvalid = 1'b0;
        check("b2b_first_done",   64'(d1),           7);
        check("b2b_done_spacing", 64'(d2 - d1),      8);
        check("b2b_res1",         64'(r1),           300);
        check("b2b_res2",         64'(r2),           -32768);
        check("b2b_sat2",         64'(s2),           1);
        check("b2b_idle_between", 64'(idle_between), 1);
        @(posedge ap_clk); #1;

        // Reset for one cycle after two accepts.
        wrom     = vecs[0].w;
        ap_start = 1'b1;
        bias     = '0;
        x_tvalid = 1'b1;
        x_tdata  = 13'd1;
        @(posedge ap_clk); #1;          // cycle 1: accept x=1
        ap_start = 1'b0;
        @(posedge ap_clk); #1;          // cycle 2: accept x=2
        x_tdata  = 13'd2;
        @(posedge ap_clk); #1;          // cycle 3: reset asserted
        x_tdata  = 13'd3;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check_reset_outputs("midrst");
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        done_cnt = 0; idle_cnt = 0; tready_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge ap_clk);
            if (ap_done)  done_cnt++;
            if (ap_idle)  idle_cnt++;
            if (x_tready) tready_cnt++;
            @(posedge ap_clk); #1;
        end
        x_tvalid = 1'b0;
        check("midrst_no_done",    64'(done_cnt),   0);
        check("midrst_stays_idle", 64'(idle_cnt),   12);
        check("midrst_no_tready",  64'(tready_cnt), 0);
        run_vec(0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
